// File: rtl/bus2_pkg.sv
// rtl/bus2_pkg.sv - shared bus2 widths, C2 command codes and master FSM state type
package bus2_pkg;

    localparam int ADDR2_BUS_SIZE  = 14;
    localparam int DATA_BUS_SIZE   = 16;
    localparam int CTR2_BUS_SIZE   = 2;
    localparam int CACHE_LINE_SIZE = 16;

    localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = 2'd0;
    localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = 2'd1;
    localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = 2'd2;
    localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_WAIT,
        DONE
    } bus2_master_state_t;

endpackage

// File: rtl/bus2_tristate_drv.sv
// rtl/bus2_tristate_drv.sv - single bus driver: drives value when en, else floats to Z
// Ports:
//   en    - output enable
//   value - value driven while enabled
//   pad   - shared bus line
module bus2_tristate_drv #(
    parameter int W = 1
) (
    input  logic         en,
    input  logic [W-1:0] value,
    inout  wire  [W-1:0] pad
);

    assign pad = en ? value : {W{1'bz}};

endmodule

// File: rtl/bus2_line_master.sv
// rtl/bus2_line_master.sv - cache-side bus2 initiator moving one whole line per request
// Optional feature macro: BUS2_TIMEOUT_EN (watchdog in the wait states, adds rsp_err).
// Ports:
//   CLK, RESET          - clock, asynchronous active-high reset
//   A2_WIRE             - line address, driven in the command cycle only
//   D2_WIRE             - 16-bit data beats (byte 2k on [7:0], byte 2k+1 on [15:8])
//   C2_WIRE             - command / response code
//   req_valid/req_ready - request handshake (ready only in IDLE)
//   req_write           - 1 = write line, 0 = read line
//   req_addr, req_wdata - line address and write line (byte i at [8i+7:8i])
//   rsp_valid           - one-cycle completion pulse
//   rsp_rdata           - last completed read line, held until the next read completes
//   busy                - high in every state except IDLE
//   rsp_err             - (BUS2_TIMEOUT_EN only) completion caused by watchdog expiry
module bus2_line_master
    import bus2_pkg::*;
#(
    parameter int ADDR2_BUS_SIZE  = bus2_pkg::ADDR2_BUS_SIZE,
    parameter int DATA_BUS_SIZE   = bus2_pkg::DATA_BUS_SIZE,
    parameter int CTR2_BUS_SIZE   = bus2_pkg::CTR2_BUS_SIZE,
    parameter int CACHE_LINE_SIZE = bus2_pkg::CACHE_LINE_SIZE
`ifdef BUS2_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 255
`endif
) (
    input  logic                         CLK,
    input  logic                         RESET,
    inout  wire  [ADDR2_BUS_SIZE-1:0]    A2_WIRE,
    inout  wire  [DATA_BUS_SIZE-1:0]     D2_WIRE,
    inout  wire  [CTR2_BUS_SIZE-1:0]     C2_WIRE,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR2_BUS_SIZE-1:0]    req_addr,
    input  logic [CACHE_LINE_SIZE*8-1:0] req_wdata,
    output logic                         rsp_valid,
    output logic [CACHE_LINE_SIZE*8-1:0] rsp_rdata,
    output logic                         busy
`ifdef BUS2_TIMEOUT_EN
    ,
    output logic                         rsp_err
`endif
);

    localparam int BEATS  = CACHE_LINE_SIZE / 2;
    localparam int LINE_W = CACHE_LINE_SIZE * 8;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    bus2_master_state_t state, state_nx;

    logic [CNT_W-1:0]          cnt;
    logic [ADDR2_BUS_SIZE-1:0] addr_q;
    logic [LINE_W-1:0]         wdata_q;
    logic [LINE_W-1:0]         rbuf_q;
    logic [LINE_W-1:0]         rbuf_merged;

    logic                      a2_en, d2_en, c2_en;
    logic [CTR2_BUS_SIZE-1:0]  c2_val;
    logic [DATA_BUS_SIZE-1:0]  d2_val;

    // X/Z on C2 never compares equal to RESPONSE, so noise is ignored
    logic resp_seen;
    assign resp_seen = (C2_WIRE == C2_RESPONSE);

    logic timeout;

`ifdef BUS2_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            in_wait;

    assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);
    assign timeout = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Counter is zero outside the wait states, so it restarts on every entry.
    // err_q is only meaningful during DONE: it records whether DONE was
    // reached by expiry rather than by a response.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= in_wait ? wd_cnt + WD_W'(1) : '0;
            err_q  <= in_wait && timeout && !resp_seen;
        end
    end

    assign rsp_err = (state == DONE) && err_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        a2_en    = 1'b0;
        d2_en    = 1'b0;
        c2_en    = 1'b0;
        c2_val   = C2_NOP;
        d2_val   = wdata_q[cnt*DATA_BUS_SIZE +: DATA_BUS_SIZE];
        case (state)
            IDLE: begin
                if (req_valid) state_nx = req_write ? WR_DATA : RD_CMD;
            end
            RD_CMD: begin
                a2_en    = 1'b1;
                c2_en    = 1'b1;
                c2_val   = C2_READ_LINE;
                state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                if (resp_seen)    state_nx = RD_DATA;
                else if (timeout) state_nx = DONE;
            end
            RD_DATA: begin
                if (cnt == LAST_BEAT) state_nx = DONE;
            end
            WR_DATA: begin
                c2_en  = 1'b1;
                d2_en  = 1'b1;
                c2_val = C2_WRITE_LINE;
                a2_en  = (cnt == '0);
                if (cnt == LAST_BEAT) state_nx = WR_WAIT;
            end
            WR_WAIT: begin
                if (resp_seen || timeout) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Current read buffer with the beat on D2 merged in at slot cnt
    always_comb begin
        rbuf_merged = rbuf_q;
        rbuf_merged[cnt*DATA_BUS_SIZE +: DATA_BUS_SIZE] = D2_WIRE;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                RD_WAIT: begin
                    if (resp_seen) begin
                        rbuf_q <= rbuf_merged;
                        cnt    <= cnt + 1'b1;
                    end
                end
                RD_DATA: begin
                    rbuf_q <= rbuf_merged;
                    if (cnt == LAST_BEAT) begin
                        rsp_rdata <= rbuf_merged;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_DATA: cnt <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == DONE);

    bus2_tristate_drv #(.W(ADDR2_BUS_SIZE)) u_a2_drv (.en(a2_en), .value(addr_q), .pad(A2_WIRE));
    bus2_tristate_drv #(.W(DATA_BUS_SIZE))  u_d2_drv (.en(d2_en), .value(d2_val), .pad(D2_WIRE));
    bus2_tristate_drv #(.W(CTR2_BUS_SIZE))  u_c2_drv (.en(c2_en), .value(c2_val), .pad(C2_WIRE));

endmodule

// File: tb/tb_bus2_line_master.sv
// tb/tb_bus2_line_master.sv - randomized self-checking bench for bus2_line_master
module tb_bus2_line_master;
    import bus2_pkg::*;

    localparam int BEATS = CACHE_LINE_SIZE / 2;
    localparam int LW    = CACHE_LINE_SIZE * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wire [ADDR2_BUS_SIZE-1:0] a2;
    wire [DATA_BUS_SIZE-1:0]  d2;
    wire [CTR2_BUS_SIZE-1:0]  c2;

    logic                     rsp_c2_en = 1'b0;
    logic                     rsp_d2_en = 1'b0;
    logic [CTR2_BUS_SIZE-1:0] rsp_c2    = C2_NOP;
    logic [DATA_BUS_SIZE-1:0] rsp_d2    = '0;
    assign c2 = rsp_c2_en ? rsp_c2 : 'z;
    assign d2 = rsp_d2_en ? rsp_d2 : 'z;

    logic                      req_valid = 1'b0;
    logic                      req_write = 1'b0;
    logic [ADDR2_BUS_SIZE-1:0] req_addr  = '0;
    logic [LW-1:0]             req_wdata = '0;
    logic                      req_ready, rsp_valid, busy;
    logic [LW-1:0]             rsp_rdata;
`ifdef BUS2_TIMEOUT_EN
    logic                      rsp_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [LW-1:0] last_rd = '0;

    wire [2:0] drv_en = {dut.a2_en, dut.d2_en, dut.c2_en};
    wire [2:0] status = {req_ready, busy, rsp_valid};

`ifdef BUS2_TIMEOUT_EN
    bus2_line_master #(.TIMEOUT_CYCLES(10)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .A2_WIRE   (a2),
        .D2_WIRE   (d2),
        .C2_WIRE   (c2),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .rsp_err   (rsp_err)
    );
`else
    bus2_line_master dut (
        .CLK       (clk),
        .RESET     (rst),
        .A2_WIRE   (a2),
        .D2_WIRE   (d2),
        .C2_WIRE   (c2),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );
`endif

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_read(input logic [ADDR2_BUS_SIZE-1:0] addr, input logic [LW-1:0] line,
                           input int delay, input bit noise, input bit keep_valid, input int abort_at);
        chk("rd_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_wdata = rand_line();
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
        chk("rd_cmd_c2", c2, C2_READ_LINE);
        chk("rd_cmd_a2", a2, addr);
        chk("rd_cmd_en", drv_en, 3'b101);
        chk("rd_cmd_status", status, 3'b010);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            chk("rd_wait_en", drv_en, 3'b000);
            chk("rd_wait_status", status, 3'b010);
            rsp_c2    = C2_NOP;
            rsp_c2_en = noise && (k < 4);
        end
        for (int b = 0; b < BEATS; b++) begin
            if (b == abort_at) begin
                rsp_c2_en = 1'b0;
                rsp_d2_en = 1'b0;
                rst = 1'b1;
                #1;
                chk("abort_en", drv_en, 3'b000);
                chk("abort_status", status, 3'b100);
                chk("abort_rdata", rsp_rdata, '0);
                last_rd = '0;
                @(negedge clk);
                chk("abort_no_pulse", rsp_valid, 0);
                rst = 1'b0;
                return;
            end
            rsp_c2_en = 1'b1;
            rsp_c2    = C2_RESPONSE;
            rsp_d2_en = 1'b1;
            rsp_d2    = line[b*16 +: 16];
            @(negedge clk);
            chk("rd_data_en", drv_en, 3'b000);
            if (b < BEATS - 1) begin
                chk("rd_data_status", status, 3'b010);
                chk("rd_rdata_held", rsp_rdata, last_rd);
            end
        end
        rsp_c2_en = 1'b0;
        rsp_d2_en = 1'b0;
        last_rd   = line;
        chk("rd_done_status", status, 3'b011);
        chk("rd_rdata", rsp_rdata, line);
`ifdef BUS2_TIMEOUT_EN
        chk("rd_err", rsp_err, 0);
`endif
        @(negedge clk);
        chk("rd_idle_status", status, 3'b100);
        chk("rd_idle_en", drv_en, 3'b000);
        chk("rd_rdata_after", rsp_rdata, last_rd);
    endtask

    task automatic do_write(input logic [ADDR2_BUS_SIZE-1:0] addr, input logic [LW-1:0] wdata,
                            input int delay);
        chk("wr_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = rand_line();
        for (int b = 0; b < BEATS; b++) begin
            chk("wr_c2", c2, C2_WRITE_LINE);
            chk("wr_d2", d2, wdata[b*16 +: 16]);
            chk("wr_en", drv_en, {b == 0, 2'b11});
            if (b == 0) chk("wr_a2", a2, addr);
            chk("wr_status", status, 3'b010);
            @(negedge clk);
        end
        for (int k = 0; k < delay; k++) begin
            chk("wr_wait_en", drv_en, 3'b000);
            chk("wr_wait_status", status, 3'b010);
            @(negedge clk);
        end
        chk("wr_wait_en", drv_en, 3'b000);
        rsp_c2_en = 1'b1;
        rsp_c2    = C2_RESPONSE;
        @(negedge clk);
        rsp_c2_en = 1'b0;
        chk("wr_done_status", status, 3'b011);
        chk("wr_done_en", drv_en, 3'b000);
        chk("wr_rdata_held", rsp_rdata, last_rd);
`ifdef BUS2_TIMEOUT_EN
        chk("wr_err", rsp_err, 0);
`endif
        @(negedge clk);
        chk("wr_idle_status", status, 3'b100);
        chk("wr_idle_en", drv_en, 3'b000);
    endtask

`ifdef BUS2_TIMEOUT_EN
    task automatic do_timeout(input logic [ADDR2_BUS_SIZE-1:0] addr);
        chk("to_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("to_wait_valid", rsp_valid, 0);
        end
        @(negedge clk);
        chk("to_done", {rsp_valid, rsp_err}, 2'b11);
        chk("to_rdata", rsp_rdata, last_rd);
        @(negedge clk);
        chk("to_idle", {status, rsp_err}, 4'b1000);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        logic [LW-1:0] line;
        repeat (2) @(negedge clk);
        chk("reset_status", status, 3'b100);
        chk("reset_en", drv_en, 3'b000);
        chk("reset_rdata", rsp_rdata, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_status", status, 3'b100);

        for (int i = 0; i < CACHE_LINE_SIZE; i++) line[i*8 +: 8] = 8'(i * 3);
        do_read(14'h0A5, line, 6, 1'b0, 1'b0, -1);

        for (int i = 0; i < CACHE_LINE_SIZE; i++) line[i*8 +: 8] = 8'hF0 ^ 8'(i);
        do_write(14'h3FF, line, 3);

        do_read(14'($urandom), rand_line(), 2, 1'b0, 1'b1, -1);
        do_write(14'($urandom), rand_line(), 1);

        do_read(14'h155, rand_line(), 4, 1'b0, 1'b0, 3);
        do_read(14'h2AA, rand_line(), 1, 1'b0, 1'b0, -1);

        do_read(14'h1C3, rand_line(), 7, 1'b1, 1'b0, -1);

        repeat (24) begin
            if ($urandom_range(0, 1) == 1)
                do_read(14'($urandom), rand_line(), int'($urandom_range(1, 8)), 1'b0, 1'b0, -1);
            else
                do_write(14'($urandom), rand_line(), int'($urandom_range(0, 8)));
        end

`ifdef BUS2_TIMEOUT_EN
        do_timeout(14'h0F0);
        do_read(14'h0F1, rand_line(), 3, 1'b0, 1'b0, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
